// File: rtl/cell_comm_pkg.sv
// Shared header layout, defaults and RX state encoding
// for the cell-communication receive path.
package cell_comm_pkg;

  localparam int MAGIC_LSB = 24;
  localparam int MAGIC_W   = 8;
  localparam int CELL_LSB  = 16;
  localparam int CELL_W    = 8;
  localparam int BPM_LSB   = 8;
  localparam int BPM_W     = 8;
  localparam int CNT_LSB   = 0;
  localparam int CNT_W     = 8;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_PAYLOAD,
    RX_DISCARD
  } rx_state_e;

  function automatic logic [MAGIC_W-1:0] hdr_magic(
    input logic [31:0] w
  );
    return w[MAGIC_LSB +: MAGIC_W];
  endfunction

  function automatic logic [CNT_W-1:0] hdr_count(
    input logic [31:0] w
  );
    return w[CNT_LSB +: CNT_W];
  endfunction

endpackage

// File: rtl/cell_comm_rx_packet_filter_if.sv
// Link-side RX beats plus the forwarded output stream
// of the cell-communication packet filter.
interface cell_comm_rx_packet_filter_if;

  logic        channelUp;
  logic        rxTvalid;
  logic        rxTlast;
  logic [31:0] rxTdata;
  logic        rxCRCvalid;
  logic        rxCRCpass;
  logic        outTvalid;
  logic        outTready;
  logic        outTlast;
  logic [31:0] outTdata;

  modport master (
    output channelUp, rxTvalid, rxTlast,
    output rxTdata, rxCRCvalid, rxCRCpass,
    output outTready,
    input  outTvalid, outTlast, outTdata
  );

  modport slave (
    input  channelUp, rxTvalid, rxTlast,
    input  rxTdata, rxCRCvalid, rxCRCpass,
    input  outTready,
    output outTvalid, outTlast, outTdata
  );

endinterface

// File: rtl/cell_comm_pkt_ram.sv
// Packet buffer: one write port, one registered read port.
// Contents are not reset; pointers elsewhere define validity.
module cell_comm_pkt_ram #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cell_comm_rx_packet_filter.sv
// Validates incoming FA packets, commits good ones to the
// packet buffer and streams committed words downstream.
module cell_comm_rx_packet_filter
  import cell_comm_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 9,
  parameter logic [7:0] MAGIC       = MAGIC_DEFAULT,
  parameter logic [7:0] MAX_PAYLOAD = 8'd32
) (
  input  logic        auroraUserClk,
  input  logic        auroraUserResetN,
  cell_comm_rx_packet_filter_if.slave link,
  output logic [15:0] goodPackets,
  output logic [15:0] badMagic,
  output logic [15:0] badLength,
  output logic [15:0] badCRC,
  output logic [15:0] overflows
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  rx_state_e   st_q;
  logic [7:0]  cnt_q;
  logic [AW:0] wr_q, commit_q, rd_q;
  logic [15:0] good_q, mag_q, len_q, crc_q, ovf_q;

  logic [7:0]  n;
  logic        magic_ok, len_ok, hdr_ok, crc_ok;
  logic        full, beat, we;

  always_comb begin
    n        = hdr_count(link.rxTdata);
    magic_ok = hdr_magic(link.rxTdata) == MAGIC;
    len_ok   = (n != 8'd0) && (n <= MAX_PAYLOAD)
               && !link.rxTlast;
    hdr_ok   = magic_ok && len_ok;
    crc_ok   = link.rxCRCvalid && link.rxCRCpass;
    full     = (wr_q - rd_q) == DEPTH;
    beat     = link.rxTvalid && link.channelUp;
    we       = beat && !full
               && ((st_q == RX_PAYLOAD)
               || (st_q == RX_IDLE && hdr_ok));
  end

  always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
    if (!auroraUserResetN) begin
      st_q     <= RX_IDLE;
      cnt_q    <= '0;
      wr_q     <= '0;
      commit_q <= '0;
      good_q   <= '0;
      mag_q    <= '0;
      len_q    <= '0;
      crc_q    <= '0;
      ovf_q    <= '0;
    end else if (!link.channelUp) begin
      st_q <= RX_IDLE;
      wr_q <= commit_q;
    end else if (link.rxTvalid) begin
      unique case (st_q)
        RX_IDLE: begin
          if (full) begin
            ovf_q <= ovf_q + 16'd1;
            st_q  <= link.rxTlast ? RX_IDLE : RX_DISCARD;
          end else if (hdr_ok) begin
            wr_q  <= wr_q + ONE;
            cnt_q <= n;
            st_q  <= RX_PAYLOAD;
          end else begin
            if (!magic_ok) mag_q <= mag_q + 16'd1;
            else           len_q <= len_q + 16'd1;
            st_q <= link.rxTlast ? RX_IDLE : RX_DISCARD;
          end
        end
        RX_PAYLOAD: begin
          if (full) begin
            wr_q  <= commit_q;
            ovf_q <= ovf_q + 16'd1;
            st_q  <= link.rxTlast ? RX_IDLE : RX_DISCARD;
          end else if (cnt_q == 8'd1) begin
            if (!link.rxTlast) begin
              wr_q  <= commit_q;
              len_q <= len_q + 16'd1;
              st_q  <= RX_DISCARD;
            end else if (crc_ok) begin
              wr_q     <= wr_q + ONE;
              commit_q <= wr_q + ONE;
              good_q   <= good_q + 16'd1;
              st_q     <= RX_IDLE;
            end else begin
              wr_q  <= commit_q;
              crc_q <= crc_q + 16'd1;
              st_q  <= RX_IDLE;
            end
          end else if (link.rxTlast) begin
            wr_q  <= commit_q;
            len_q <= len_q + 16'd1;
            st_q  <= RX_IDLE;
          end else begin
            wr_q  <= wr_q + ONE;
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RX_DISCARD: begin
          if (link.rxTlast) st_q <= RX_IDLE;
        end
        default: st_q <= RX_IDLE;
      endcase
    end
  end

  logic [31:0] rdata;
  logic        rd_en, pop, push_last;
  logic [2:0]  slots;
  logic        rvalid_q, rhdr_q;
  logic [7:0]  rcnt_q;
  logic [1:0]  occ_q;
  logic [31:0] d0_q, d1_q;
  logic        l0_q, l1_q;

  cell_comm_pkt_ram #(
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk_i   (auroraUserClk),
    .we_i    (we),
    .waddr_i (wr_q[AW-1:0]),
    .wdata_i (link.rxTdata),
    .re_i    (rd_en),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (rdata)
  );

  // Issue a read only if the skid pair can absorb it
  // counting the word already in flight from the RAM.
  always_comb begin
    pop       = (occ_q != 2'd0) && link.outTready;
    slots     = {1'b0, occ_q} + {2'b0, rvalid_q}
                - {2'b0, pop};
    rd_en     = (commit_q != rd_q) && (slots < 3'd2);
    push_last = !rhdr_q && (rcnt_q == 8'd1);
  end

  always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
    if (!auroraUserResetN) begin
      rd_q     <= '0;
      rvalid_q <= 1'b0;
      rhdr_q   <= 1'b1;
      rcnt_q   <= '0;
      occ_q    <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      l0_q     <= 1'b0;
      l1_q     <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) rd_q <= rd_q + ONE;
      if (rvalid_q) begin
        if (rhdr_q) begin
          rcnt_q <= hdr_count(rdata);
          rhdr_q <= 1'b0;
        end else begin
          rcnt_q <= rcnt_q - 8'd1;
          if (push_last) rhdr_q <= 1'b1;
        end
      end
      unique case ({rvalid_q, pop})
        2'b11: begin
          if (occ_q == 2'd1) begin
            d0_q <= rdata;
            l0_q <= push_last;
          end else begin
            d0_q <= d1_q;
            l0_q <= l1_q;
            d1_q <= rdata;
            l1_q <= push_last;
          end
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            d0_q <= rdata;
            l0_q <= push_last;
          end else begin
            d1_q <= rdata;
            l1_q <= push_last;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          d0_q  <= d1_q;
          l0_q  <= l1_q;
          occ_q <= occ_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign link.outTvalid = occ_q != 2'd0;
  assign link.outTdata  = d0_q;
  assign link.outTlast  = l0_q;

  assign goodPackets = good_q;
  assign badMagic    = mag_q;
  assign badLength   = len_q;
  assign badCRC      = crc_q;
  assign overflows   = ovf_q;

endmodule

// File: tb/tb_cell_comm_rx_packet_filter.sv
// Directed scoreboard bench for the RX packet filter
// with a 16-word buffer.
module tb_cell_comm_rx_packet_filter;
  import cell_comm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cell_comm_rx_packet_filter_if bus();

  logic [15:0] goodPackets, badMagic, badLength;
  logic [15:0] badCRC, overflows;

  cell_comm_rx_packet_filter #(
    .ADDR_WIDTH (4)
  ) dut (
    .auroraUserClk    (clk),
    .auroraUserResetN (rst_n),
    .link             (bus),
    .goodPackets      (goodPackets),
    .badMagic         (badMagic),
    .badLength        (badLength),
    .badCRC           (badCRC),
    .overflows        (overflows)
  );

  logic [32:0] sb[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] e_good = 0, e_mag = 0, e_len = 0;
  logic [15:0] e_crc = 0, e_ovf = 0;
  logic [31:0] seq = 32'hC0DE_0000;
  logic [31:0] held;

  task automatic chk(input string tag,
                     input logic [32:0] got,
                     input logic [32:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.outTvalid && bus.outTready) begin
      if (sb.size() == 0)
        chk("sb_nonempty", 33'(sb.size()), 33'd1);
      else
        chk("out_word", {bus.outTlast, bus.outTdata},
            sb.pop_front());
    end
  end

  task automatic beat(input logic [31:0] d, input logic last,
                      input logic cv, input logic cp);
    bus.rxTvalid   = 1'b1;
    bus.rxTdata    = d;
    bus.rxTlast    = last;
    bus.rxCRCvalid = cv & last;
    bus.rxCRCpass  = cp & last;
    @(posedge clk); #1;
    bus.rxTvalid   = 1'b0;
    bus.rxTlast    = 1'b0;
    bus.rxCRCvalid = 1'b0;
    bus.rxCRCpass  = 1'b0;
  endtask

  task automatic send(input logic [31:0] hdr, input int nw,
                      input int last_at, input logic cv,
                      input logic cp, input logic good);
    logic [31:0] d;
    for (int i = 0; i < nw; i++) begin
      d = (i == 0) ? hdr : seq;
      if (i != 0) seq = seq + 32'd1;
      beat(d, i == last_at, cv, cp);
      if (good) sb.push_back({i == nw - 1, d});
    end
  endtask

  task automatic good_pkt();
    send(32'hA5010203, 4, 3, 1'b1, 1'b1, 1'b1);
    e_good = e_good + 16'd1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !bus.outTvalid) break;
      @(posedge clk); #1;
    end
    chk(tag, 33'(sb.size()), 33'd0);
  endtask

  task automatic ctrs(input string tag);
    chk({tag, "_good"}, 33'(goodPackets), 33'(e_good));
    chk({tag, "_mag"},  33'(badMagic),    33'(e_mag));
    chk({tag, "_len"},  33'(badLength),   33'(e_len));
    chk({tag, "_crc"},  33'(badCRC),      33'(e_crc));
    chk({tag, "_ovf"},  33'(overflows),   33'(e_ovf));
  endtask

  initial begin
    bus.channelUp  = 1'b1;
    bus.outTready  = 1'b1;
    bus.rxTvalid   = 1'b0;
    bus.rxTlast    = 1'b0;
    bus.rxTdata    = '0;
    bus.rxCRCvalid = 1'b0;
    bus.rxCRCpass  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 33'(bus.outTvalid), 33'd0);
    chk("rst_last",  33'(bus.outTlast),  33'd0);
    chk("rst_data",  33'(bus.outTdata),  33'd0);
    ctrs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Good packet and commit latency
    send(32'hA5030703, 4, 3, 1'b1, 1'b1, 1'b1);
    e_good = e_good + 16'd1;
    chk("lat_t1", 33'(bus.outTvalid), 33'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("lat_t3", 33'(bus.outTvalid), 33'd1);
    drain("drain_good");
    ctrs("good");

    // CRC fail, missing CRC valid, then good
    send(32'hA5030703, 4, 3, 1'b1, 1'b0, 1'b0);
    e_crc = e_crc + 16'd1;
    good_pkt();
    send(32'hA5030703, 4, 3, 1'b0, 1'b1, 1'b0);
    e_crc = e_crc + 16'd1;
    drain("drain_crc");
    ctrs("crc");

    // Bad magic, multi-beat and single-beat
    send(32'h5A000002, 3, 2, 1'b1, 1'b1, 1'b0);
    e_mag = e_mag + 16'd1;
    send(32'h5A000002, 1, 0, 1'b1, 1'b1, 1'b0);
    e_mag = e_mag + 16'd1;
    good_pkt();
    drain("drain_mag");
    ctrs("mag");

    // Length errors and smallest legal packet
    send(32'hA5000004, 4, 3, 1'b1, 1'b1, 1'b0);
    e_len = e_len + 16'd1;
    send(32'hA5000000, 2, 1, 1'b1, 1'b1, 1'b0);
    e_len = e_len + 16'd1;
    send(32'hA5000002, 6, 5, 1'b1, 1'b1, 1'b0);
    e_len = e_len + 16'd1;
    send(32'hA5000021, 2, 1, 1'b1, 1'b1, 1'b0);
    e_len = e_len + 16'd1;
    good_pkt();
    send(32'hA5000001, 2, 1, 1'b1, 1'b1, 1'b1);
    e_good = e_good + 16'd1;
    drain("drain_len");
    ctrs("len");

    // Overflow with output stalled
    bus.outTready = 1'b0;
    send(32'hA5000007, 8, 7, 1'b1, 1'b1, 1'b1);
    send(32'hA5000007, 8, 7, 1'b1, 1'b1, 1'b1);
    send(32'hA5000007, 8, 7, 1'b1, 1'b1, 1'b0);
    e_good = e_good + 16'd2;
    e_ovf  = e_ovf + 16'd1;
    held = bus.outTdata;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_valid", 33'(bus.outTvalid), 33'd1);
    chk("hold_data",  33'(bus.outTdata), 33'(held));
    chk("hold_head",  {bus.outTlast, bus.outTdata}, sb[0]);
    chk("ovf_queued", 33'(sb.size()), 33'd16);
    ctrs("ovf");
    bus.outTready = 1'b1;
    drain("drain_ovf");

    // Channel loss mid-packet
    beat(32'hA5000005, 1'b0, 1'b0, 1'b0);
    beat(32'h1111_0001, 1'b0, 1'b0, 1'b0);
    beat(32'h1111_0002, 1'b0, 1'b0, 1'b0);
    bus.channelUp = 1'b0;
    beat(32'h1111_0003, 1'b0, 1'b0, 1'b0);
    beat(32'h1111_0004, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    bus.channelUp = 1'b1;
    @(posedge clk); #1;
    ctrs("chdown");
    good_pkt();
    drain("drain_chan");
    ctrs("chan");

    // Reset while streaming
    good_pkt();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() < 4) break;
      @(negedge clk);
    end
    chk("stream_started", 33'(sb.size() < 4), 33'd1);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    e_good = 0; e_mag = 0; e_len = 0; e_crc = 0; e_ovf = 0;
    chk("mrst_valid", 33'(bus.outTvalid), 33'd0);
    chk("mrst_data",  33'(bus.outTdata),  33'd0);
    ctrs("mrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    good_pkt();
    drain("drain_post");
    ctrs("post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cell_comm_rx_packet_filter.md
# cell_comm_rx_packet_filter

Receive-side packet filter for one cell-communication link (CCW or CW). It sits directly downstream of the Aurora link's RX AXI stream and CRC sideband, in the Aurora user-clock domain. Each incoming FA packet is buffered while it is checked for header magic, length and CRC. Only fully validated packets are committed to an internal packet FIFO and forwarded on an AXI stream to the FA merge logic; everything else is rolled back and counted.

## Interface
Parameters:
- `ADDR_WIDTH`, 9: packet buffer depth is 2^ADDR_WIDTH 32-bit words.
- `MAGIC`, 8'hA5: required value of header bits [31:24].
- `MAX_PAYLOAD`, 8'd32: largest legal payload word count.

Ports:
- `auroraUserClk`  in  1  Aurora user clock; the only clock.
- `auroraUserResetN`  in  1  asynchronous, active-low reset.
- `channelUp`  in  1  Aurora channel up.
- `rxTvalid`  in  1  Aurora RX beat valid. There is no ready signal; the block must accept every beat.
- `rxTlast`  in  1  last beat of packet.
- `rxTdata`  in  32  RX data.
- `rxCRCvalid`  in  1  CRC result valid; meaningful only on the `rxTlast` beat.
- `rxCRCpass`  in  1  CRC passed.
- `outTvalid`  out  1  forwarded stream valid.
- `outTready`  in  1  downstream ready.
- `outTlast`  out  1  last word of forwarded packet.
- `outTdata`  out  32  forwarded word. Header first, then payload.
- `goodPackets`  out  16  committed packets, wrapping.
- `badMagic`  out  16  header magic errors, wrapping.
- `badLength`  out  16  length errors, wrapping.
- `badCRC`  out  16  CRC errors, wrapping.
- `overflows`  out  16  packets dropped because the buffer was full, wrapping.

## Operation
- **Header word layout:** [31:24] magic, [23:16] cell index, [15:8] BPM index, [7:0] payload count N.
- **Packet shape:** a packet is the header plus N payload words. `rxTlast` must be on payload word N.
- **Pointers:** `wrPtr`, `commitPtr` and `rdPtr` are each ADDR_WIDTH+1 bits wide.
  - Buffer is full when `wrPtr - rdPtr == 2^ADDR_WIDTH`.
  - The read side sees only `commitPtr`.
- **RX FSM states:** IDLE, PAYLOAD, DISCARD.
- **IDLE, on a valid beat:**
  - Header is good when magic equals MAGIC, 1 ≤ N ≤ MAX_PAYLOAD, and `rxTlast`=0. Then write the word, load the remaining count with N, go to PAYLOAD.
  - Bad magic takes priority: `badMagic`++.
  - Otherwise `badLength`++.
  - After an error, go to DISCARD, or stay in IDLE if the beat had `rxTlast`=1.
- **PAYLOAD, on a valid beat:** write the word and decrement the count.
  - Count reaches 0 with `rxTlast`=1:
    - If `rxCRCvalid`=1 and `rxCRCpass`=1: `commitPtr` ← `wrPtr`+1, `goodPackets`++.
    - Otherwise (a missing `rxCRCvalid` counts as a failure): roll back, `badCRC`++.
    - Go to IDLE in both cases.
  - `rxTlast` before count 0: roll back, `badLength`++, go to IDLE.
  - Count reaches 0 with `rxTlast`=0: roll back, `badLength`++, go to DISCARD.
- **DISCARD:** drop beats until a beat with `rxTlast`=1, then go to IDLE.
- **Rollback:** `wrPtr` ← `commitPtr`.
- **Overflow:** a valid beat arriving while the buffer is full, in IDLE or PAYLOAD:
  - roll back and increment `overflows`;
  - go to DISCARD, or to IDLE if the beat had `rxTlast`=1;
  - no other counter increments for that packet.
- **Priority and simultaneous events:**
  - Overflow has priority over the length and CRC checks.
  - Only one counter increments per packet.
- **Channel loss:** `channelUp`=0 forces IDLE and rolls back any uncommitted packet, with no counter change. Beats received while `channelUp`=0 are ignored.
- **Read side:** streams committed words in order. `outTlast` is asserted on the final payload word, tracked by re-reading the header count.

## Timing
- **Reset values:** all counters 0, all pointers 0, FSM in IDLE, `outTvalid`=0, `outTlast`=0, `outTdata`=0.
- **Commit latency:** the committing beat arrives in cycle t, `commitPtr` is visible in t+1, and `outTvalid` rises no earlier than t+2 and no later than t+3 when the output is empty.
- **Handshake:**
  - A word transfers when `outTvalid` and `outTready` are both 1.
  - `outTvalid` and `outTdata` hold stable while `outTready`=0.
  - Sustained throughput is 1 word/cycle.
- **Buffer space:** freed space (`rdPtr` advance) is visible to the full check on the next cycle.
- **Reset mid-operation:** all state clears immediately. Any partially sent output packet is abandoned, so downstream must also be reset.

## Structure
- **Package `cell_comm_pkg`:** header field offsets and widths, default MAGIC, RX FSM state encoding.
- **Sub-module `cell_comm_pkt_ram`:** simple dual-port RAM with one write port and a registered read port, depth 2^ADDR_WIDTH × 32.
- **Output register:** the output stage is a 2-entry skid/output register inside the top level.

## Test plan
- **Good packet:** header 0xA5030703, then 3 payload words, `rxTlast` and CRC pass on word 3 → exactly 4 words out in order, `outTlast` on word 4, `goodPackets`=1.
- **CRC failure:** same packet with `rxCRCpass`=0, then a good packet → only the second packet appears at the output, `badCRC`=1, `goodPackets`=1.
- **Bad magic:** header 0x5A000002 followed by 2 words → nothing out, `badMagic`=1, FSM in IDLE after `rxTlast`.
- **Length errors:**
  - N=4 with `rxTlast` on payload 3 → `badLength`=1.
  - N=0 → `badLength`=2.
  - N=2 with no `rxTlast` until word 5 → `badLength`=3, and the next good packet is forwarded intact.
- **Overflow:** ADDR_WIDTH=4, `outTready`=0, three packets of N=7 sent → first two committed (16 words), third dropped, `overflows`=1. Then `outTready`=1 → 16 words out, two `outTlast` pulses.
- **Channel loss and reset:**
  - `channelUp` drops after 2 payload words of an N=5 packet → nothing out, no counter change.
  - Reset asserted while the output is streaming → `outTvalid`=0 immediately and all counters read 0.
